udp_tx_framer: RTL and testbench

//  Downstream neighbour of the old-protocol TX packet sender; runs on the same tx_clock.
//  - Grants the sender's request/enable/active byte handshake.
//  - Prepends the 8-byte UDP header (ports, length, checksum 0x0000) to the sender's payload.
//  - Streams header+payload to the IP/MAC transmit stage as one contiguous byte burst.

---
 rtl/udp_tx_framer.sv | 209 ++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: accepts one payload at a time from the TX packet sender,
// requests a burst from the IP stage, then streams the 8-byte UDP header
// (checksum 0x0000) followed by the payload as one contiguous byte burst.
//
// Optional feature macro: UDP_TX_GRANT_TIMEOUT_EN
//   When defined, a request that waits GRANT_TIMEOUT cycles without a grant
//   is dropped: the sender is still drained (enable + L active cycles) but
//   nothing is emitted, and drop_count is bumped (saturating).
//   When undefined, the framer waits for the grant indefinitely.
//
// Handshake summary: udp_tx_request is only examined in IDLE; udp_tx_enable
// is a one-cycle grant pulse; udp_tx_active is high for exactly L cycles and
// the sender advances one byte per active cycle. ip_tx_request/ip_tx_length
// are held until ip_tx_grant is sampled high; ip_tx_valid/ip_tx_data/
// ip_tx_last are registered and form a gap-free burst of L+8 bytes.
module udp_tx_framer #(
    parameter int MAX_PAYLOAD = 1032
`ifdef UDP_TX_GRANT_TIMEOUT_EN
    , parameter int GRANT_TIMEOUT = 4096
`endif
) (
    input  logic        tx_clock,
    input  logic        tx_reset_n,
    input  logic        udp_tx_request,
    input  logic [10:0] udp_tx_length,
    input  logic [7:0]  udp_tx_data,
    output logic        udp_tx_enable,
    output logic        udp_tx_active,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    output logic        ip_tx_request,
    output logic [10:0] ip_tx_length,
    input  logic        ip_tx_grant,
    output logic [7:0]  ip_tx_data,
    output logic        ip_tx_valid,
    output logic        ip_tx_last,
    output logic        length_err,
    output logic [15:0] drop_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_GRANT   = 3'd2,
        S_HDR     = 3'd3,
        S_PAYLOAD = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic        discard;

    logic [10:0] udp_len;
    logic        len_ok;
    logic [7:0]  hdr_byte;

`ifdef UDP_TX_GRANT_TIMEOUT_EN
    logic        drop_q, drop_d;
    logic [15:0] dcnt_q, dcnt_d;
    assign discard    = drop_q;
    assign drop_count = dcnt_q;
`else
    assign discard    = 1'b0;
    assign drop_count = 16'd0;
`endif

    assign udp_len = len_q + 11'd8;
    assign len_ok  = (udp_tx_length != 11'd0) && (udp_tx_length <= 11'(MAX_PAYLOAD));

    assign udp_tx_enable = (state_q == S_GRANT);
    assign udp_tx_active = (state_q == S_PAYLOAD);
    assign ip_tx_request = (state_q == S_REQ);
    assign ip_tx_length  = (state_q == S_REQ) ? udp_len : 11'd0;
    assign ip_tx_data    = data_q;
    assign ip_tx_valid   = valid_q;
    assign ip_tx_last    = last_q;
    assign length_err    = err_q;

    // Header byte selected by the header byte index
    always_comb begin
        hdr_byte = 8'h00;
        case (cnt_q[2:0])
            3'd0: hdr_byte = src_q[15:8];
            3'd1: hdr_byte = src_q[7:0];
            3'd2: hdr_byte = dst_q[15:8];
            3'd3: hdr_byte = dst_q[7:0];
            3'd4: hdr_byte = {5'b0, udp_len[10:8]};
            3'd5: hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // State register and registered output stage
    always_ff @(posedge tx_clock) begin
        if (!tx_reset_n) begin
            state_q <= S_IDLE;
            len_q   <= 11'd0;
            src_q   <= 16'd0;
            dst_q   <= 16'd0;
            cnt_q   <= 16'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UDP_TX_GRANT_TIMEOUT_EN
            drop_q  <= 1'b0;
            dcnt_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
`ifdef UDP_TX_GRANT_TIMEOUT_EN
            drop_q  <= drop_d;
            dcnt_q  <= dcnt_d;
`endif
        end
    end

    // Next-state, latching and output-byte selection
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = 8'd0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_d   = err_q;
`ifdef UDP_TX_GRANT_TIMEOUT_EN
        drop_d  = drop_q;
        dcnt_d  = dcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (udp_tx_request) begin
                    if (len_ok) begin
                        len_d   = udp_tx_length;
                        src_d   = src_port;
                        dst_d   = dst_port;
                        cnt_d   = 16'd0;
                        state_d = S_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (ip_tx_grant) begin
                    state_d = S_GRANT;
                end
`ifdef UDP_TX_GRANT_TIMEOUT_EN
                else if (cnt_q == 16'(GRANT_TIMEOUT - 1)) begin
                    // Give up on the IP stage but still drain the sender
                    state_d = S_GRANT;
                    drop_d  = 1'b1;
                    if (dcnt_q != 16'hFFFF) dcnt_d = dcnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_GRANT: begin
                cnt_d   = 16'd0;
                state_d = discard ? S_PAYLOAD : S_HDR;
            end
            S_HDR: begin
                data_d  = hdr_byte;
                valid_d = 1'b1;
                if (cnt_q == 16'd7) begin
                    cnt_d   = 16'd0;
                    state_d = S_PAYLOAD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PAYLOAD: begin
                data_d  = discard ? 8'd0 : udp_tx_data;
                valid_d = ~discard;
                if (cnt_q == {5'd0, len_q - 11'd1}) begin
                    last_d  = ~discard;
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
`ifdef UDP_TX_GRANT_TIMEOUT_EN
                    drop_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: a table of packets with hand-computed
// header fields, plus hand-written sequences for length errors,
// back-to-back requests, mid-packet reset and (with the macro) grant timeout.
module tb_udp_tx_framer;

    logic        tx_clock = 1'b0;
    logic        tx_reset_n = 1'b0;
    logic        udp_tx_request = 1'b0;
    logic [10:0] udp_tx_length = 11'd0;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_enable;
    logic        udp_tx_active;
    logic [15:0] src_port = 16'd0;
    logic [15:0] dst_port = 16'd0;
    logic        ip_tx_request;
    logic [10:0] ip_tx_length;
    logic        ip_tx_grant = 1'b0;
    logic [7:0]  ip_tx_data;
    logic        ip_tx_valid;
    logic        ip_tx_last;
    logic        length_err;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  seed = 8'h00;
    logic [10:0] sidx = 11'd0;

    typedef struct {
        logic [10:0] len;
        logic [15:0] src;
        logic [15:0] dst;
        int          gdelay;
        bit          hold;
        logic [10:0] iplen;
        logic [15:0] lenf;
        logic [7:0]  pseed;
    } vec_t;

    vec_t vecs[5];
    vec_t v;

    // clock / reset block
    always #5 tx_clock = ~tx_clock;

`ifdef UDP_TX_GRANT_TIMEOUT_EN
    udp_tx_framer #(.MAX_PAYLOAD(1032), .GRANT_TIMEOUT(16)) dut (
`else
    udp_tx_framer #(.MAX_PAYLOAD(1032)) dut (
`endif
        .tx_clock(tx_clock), .tx_reset_n(tx_reset_n),
        .udp_tx_request(udp_tx_request), .udp_tx_length(udp_tx_length),
        .udp_tx_data(udp_tx_data), .udp_tx_enable(udp_tx_enable),
        .udp_tx_active(udp_tx_active), .src_port(src_port), .dst_port(dst_port),
        .ip_tx_request(ip_tx_request), .ip_tx_length(ip_tx_length),
        .ip_tx_grant(ip_tx_grant), .ip_tx_data(ip_tx_data),
        .ip_tx_valid(ip_tx_valid), .ip_tx_last(ip_tx_last),
        .length_err(length_err), .drop_count(drop_count)
    );

    // sender model: byte k of the payload is pat(seed, k)
    function automatic logic [7:0] pat(input logic [7:0] s, input logic [10:0] k);
        logic [10:0] m;
        m = k * 11'd13;
        return (m[7:0] + s) ^ k[10:3];
    endfunction

    assign udp_tx_data = pat(seed, sidx);

    always @(posedge tx_clock) begin
        if (udp_tx_enable) sidx <= 11'd0;
        else if (udp_tx_active) sidx <= sidx + 11'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        tx_reset_n = 1'b0;
        repeat (2) @(negedge tx_clock);
        tx_reset_n = 1'b1;
        @(negedge tx_clock);
    endtask

    // one full packet; b2b: request already accepted; keep_req: hold request for the next packet
    task automatic run_pkt(input vec_t pv, input bit b2b, input bit keep_req);
        int n, en_cnt, act_cnt, bad, lastbad, total;
        logic [7:0] e;
        exp_q.delete();
        exp_q.push_back(pv.src[15:8]);
        exp_q.push_back(pv.src[7:0]);
        exp_q.push_back(pv.dst[15:8]);
        exp_q.push_back(pv.dst[7:0]);
        exp_q.push_back(pv.lenf[15:8]);
        exp_q.push_back(pv.lenf[7:0]);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        for (int k = 0; k < int'(pv.len); k++) exp_q.push_back(pat(pv.pseed, 11'(k)));
        total = int'(pv.len) + 8;
        seed = pv.pseed;
        udp_tx_request = 1'b1;
        udp_tx_length = pv.len;
        src_port = pv.src;
        dst_port = pv.dst;
        ip_tx_grant = pv.hold;
        n = 0;
        while (!ip_tx_request && n < 20) begin @(negedge tx_clock); n++; end
        check("req_latency", n, b2b ? 0 : 1);
        check("ip_tx_length", 32'(ip_tx_length), 32'(pv.iplen));
        en_cnt = 0;
        act_cnt = 0;
        repeat (pv.gdelay) begin
            en_cnt += int'(udp_tx_enable);
            @(negedge tx_clock);
        end
        check("req_held", ip_tx_request, 1);
        ip_tx_grant = 1'b1;
        @(negedge tx_clock);
        check("req_dropped", ip_tx_request, 0);
        if (!keep_req) begin
            udp_tx_request = 1'b0;
            src_port = ~pv.src;
            dst_port = ~pv.dst;
        end
        if (!pv.hold) ip_tx_grant = 1'b0;
        n = 0;
        while (!ip_tx_valid && n < 20) begin
            en_cnt += int'(udp_tx_enable);
            act_cnt += int'(udp_tx_active);
            @(negedge tx_clock);
            n++;
        end
        check("first_byte_latency", n, 2);
        bad = 0;
        lastbad = 0;
        for (int i = 0; i < total; i++) begin
            e = exp_q.pop_front();
            if (!ip_tx_valid || ip_tx_data !== e) bad++;
            if (ip_tx_last !== (i == total - 1)) lastbad++;
            en_cnt += int'(udp_tx_enable);
            act_cnt += int'(udp_tx_active);
            @(negedge tx_clock);
        end
        check("stream_bytes", bad, 0);
        check("last_flag", lastbad, 0);
        check("valid_after_last", {ip_tx_valid, ip_tx_last}, 0);
        check("enable_pulses", en_cnt, 1);
        check("active_cycles", act_cnt, int'(pv.len));
        if (keep_req) check("b2b_request", ip_tx_request, 1);
        ip_tx_grant = 1'b0;
    endtask

    task automatic bad_len(input logic [10:0] l);
        int reqs, ens;
        udp_tx_request = 1'b1;
        udp_tx_length = l;
        reqs = 0;
        ens = 0;
        repeat (6) begin
            @(negedge tx_clock);
            reqs += int'(ip_tx_request);
            ens += int'(udp_tx_enable);
        end
        check("badlen_no_ip_req", reqs, 0);
        check("badlen_no_enable", ens, 0);
        check("badlen_err", length_err, 1);
        udp_tx_request = 1'b0;
        @(negedge tx_clock);
    endtask

    initial begin
        int n, acts, vlds;
        vecs[0] = '{11'd1032, 16'd1024,  16'hC350, 3, 1'b0, 11'd1040, 16'h0410, 8'h11};
        vecs[1] = '{11'd60,   16'h1234,  16'h0043, 0, 1'b1, 11'd68,   16'h0044, 8'h5A};
        vecs[2] = '{11'd1,    16'hABCD,  16'h00FF, 1, 1'b0, 11'd9,    16'h0009, 8'h00};
        vecs[3] = '{11'd8,    16'hFFFF,  16'h0001, 5, 1'b0, 11'd16,   16'h0010, 8'hC3};
        vecs[4] = '{11'd248,  16'h8000,  16'h7FFF, 2, 1'b0, 11'd256,  16'h0100, 8'h77};

        do_reset();
        check("reset_outputs", {udp_tx_enable, udp_tx_active, ip_tx_request, ip_tx_length,
                                ip_tx_valid, ip_tx_last, ip_tx_data, length_err}, 0);
        check("reset_drop_count", drop_count, 0);

        for (int i = 0; i < 5; i++) run_pkt(vecs[i], 1'b0, 1'b0);
        check("no_err_after_good", length_err, 0);

        bad_len(11'd0);
        do_reset();
        check("err_cleared_by_reset", length_err, 0);
        bad_len(11'd1033);

        // back-to-back: request held across the end of packet 1
        v = '{11'd20, 16'h0102, 16'h0304, 1, 1'b0, 11'd28, 16'h001C, 8'h21};
        run_pkt(v, 1'b0, 1'b1);
        v.pseed = 8'h99;
        run_pkt(v, 1'b1, 1'b0);
        check("err_sticky", length_err, 1);

        // reset while payload byte 500 is being taken
        seed = 8'h3C;
        udp_tx_request = 1'b1;
        udp_tx_length = 11'd1032;
        src_port = 16'h4444;
        dst_port = 16'h5555;
        ip_tx_grant = 1'b1;
        n = 0;
        while (!(udp_tx_active && sidx == 11'd500) && n < 3000) begin @(negedge tx_clock); n++; end
        check("mid_reset_reached", n < 3000, 1);
        udp_tx_request = 1'b0;
        ip_tx_grant = 1'b0;
        tx_reset_n = 1'b0;
        @(negedge tx_clock);
        check("mid_reset_outputs", {udp_tx_enable, udp_tx_active, ip_tx_request, ip_tx_length,
                                    ip_tx_valid, ip_tx_last, ip_tx_data, length_err}, 0);
        tx_reset_n = 1'b1;
        @(negedge tx_clock);
        v = '{11'd60, 16'h0035, 16'h1F90, 2, 1'b0, 11'd68, 16'h0044, 8'hE1};
        run_pkt(v, 1'b0, 1'b0);

`ifdef UDP_TX_GRANT_TIMEOUT_EN
        // grant never given: sender drained, nothing emitted
        seed = 8'h42;
        udp_tx_request = 1'b1;
        udp_tx_length = 11'd1032;
        src_port = 16'h0001;
        dst_port = 16'h0002;
        @(negedge tx_clock);
        n = 0;
        while (ip_tx_request && n < 100) begin @(negedge tx_clock); n++; end
        check("timeout_req_cycles", n, 16);
        check("timeout_enable", udp_tx_enable, 1);
        udp_tx_request = 1'b0;
        acts = 0;
        vlds = 0;
        repeat (1100) begin
            acts += int'(udp_tx_active);
            vlds += int'(ip_tx_valid);
            @(negedge tx_clock);
        end
        check("timeout_active", acts, 1032);
        check("timeout_no_valid", vlds, 0);
        check("timeout_drop_count", drop_count, 1);
        // grant on the timeout cycle wins
        v = '{11'd1032, 16'd1024, 16'hC350, 15, 1'b0, 11'd1040, 16'h0410, 8'h66};
        run_pkt(v, 1'b0, 1'b0);
        check("timeout_grant_wins_count", drop_count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
